ghost_nav: RTL and testbench

Parametrised, tilemap-driven ghost movement controller, the generalised successor to the per-ghost hard-coded waypoint controllers. It owns one ghost's position and direction and advances on a `step` tick. At each tile-aligned position it picks the next direction from the shared `tilemap_walls` vector: the legal neighbour closest to a target tile, never reversing. Scatter corner, start tile, tile size and speed are parameters, so all four ghosts instantiate this one block beside the game-state logic.

---
 rtl/ghost_nav.sv | 239 +++++++++++++++++++++++
 tb/tb_ghost_nav.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_nav.sv
// ghost_nav: one ghost's tile-grid navigator (position, direction, target-seeking turns).
// Define GHOST_FRIGHTENED_EN to build the LFSR-driven random turns used in frightened mode.
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 32
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 16
`endif
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 320
`endif
`ifndef DIR_UP
`define DIR_UP    2'd0
`define DIR_LEFT  2'd1
`define DIR_DOWN  2'd2
`define DIR_RIGHT 2'd3
`endif

module ghost_nav #(
    parameter int         TILE_SIZE   = 20,
    parameter int         SPEED       = 20,
    parameter int         COLS        = `TILE_COL_NUM,
    parameter int         ROWS        = `TILE_ROW_NUM,
    parameter int         START_COL   = 1,
    parameter int         START_ROW   = 8,
    parameter logic [1:0] START_DIR   = `DIR_RIGHT,
    parameter int         SCATTER_COL = 0,
    parameter int         SCATTER_ROW = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic [1:0]                 mode,
    input  logic [$clog2(COLS)-1:0]    target_col,
    input  logic [$clog2(ROWS)-1:0]    target_row,
    input  logic [ROWS*COLS-1:0]       tilemap_walls,
    output logic [$clog2(`WIDTH)-1:0]  x,
    output logic [$clog2(`HEIGHT)-1:0] y,
    output logic [1:0]                 ghost_direction,
    output logic [$clog2(COLS)-1:0]    tile_col,
    output logic [$clog2(ROWS)-1:0]    tile_row,
    output logic                       busy,
    output logic                       moved
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int XW = $clog2(`WIDTH);
    localparam int YW = $clog2(`HEIGHT);
    localparam int SW = CW + RW + 1;
    localparam int OW = $clog2(TILE_SIZE + 1);
    localparam int NB = CW + RW + 1;

    typedef enum logic [1:0] {IDLE, EVAL, MOVE} state_t;

    state_t        state;
    logic [OW-1:0] offset;
    logic [1:0]    cidx, mode_q, eval_mode, mv_dir, best_dir;
    logic          rev_pend, best_vld, mv_go;
    logic [SW-1:0] best_score;

    // Packed as {off_grid, row, col}.
    function automatic logic [NB-1:0] neighbour(input logic [1:0] d,
                                                input logic [CW-1:0] c,
                                                input logic [RW-1:0] r);
        logic          off;
        logic [CW-1:0] nc;
        logic [RW-1:0] nr;
        off = 1'b0;
        nc  = c;
        nr  = r;
        case (d)
            `DIR_UP:   begin off = (r == '0);              nr = r - 1'b1; end
            `DIR_LEFT: begin off = (c == '0);              nc = c - 1'b1; end
            `DIR_DOWN: begin off = (r == RW'(ROWS - 1));   nr = r + 1'b1; end
            default:   begin off = (c == CW'(COLS - 1));   nc = c + 1'b1; end
        endcase
        return {off, nr, nc};
    endfunction

    function automatic logic tile_open(input logic [NB-1:0] nb, input logic [ROWS*COLS-1:0] walls);
        int idx;
        idx = int'(nb[CW+RW-1:CW]) * COLS + int'(nb[CW-1:0]);
        return !nb[NB-1] && (idx < ROWS * COLS) && !walls[idx];
    endfunction

    logic [1:0]    cand_dir, rev_dir, dec_dir;
    logic [NB-1:0] cand_nb, rev_nb;
    logic          cand_legal, cand_better, rev_open, dec_go;
    logic [CW-1:0] tgt_col, dc;
    logic [RW-1:0] tgt_row, dr;
    logic [SW-1:0] cand_score;
    logic [OW-1:0] off_sum;
    logic          wrap;

`ifdef GHOST_FRIGHTENED_EN
    logic [15:0] lfsr;
    logic [1:0]  rot_start, rank;

    always_ff @(posedge clk) begin
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    always_comb begin
        cand_dir   = cidx;
        rev_dir    = ghost_direction ^ 2'b10;
        cand_nb    = neighbour(cand_dir, tile_col, tile_row);
        rev_nb     = neighbour(rev_dir, tile_col, tile_row);
        rev_open   = tile_open(rev_nb, tilemap_walls);
        cand_legal = (cand_dir != rev_dir) && tile_open(cand_nb, tilemap_walls);
        tgt_col    = (eval_mode == 2'b01) ? target_col : CW'(SCATTER_COL);
        tgt_row    = (eval_mode == 2'b01) ? target_row : RW'(SCATTER_ROW);
        dc = (cand_nb[CW-1:0] >= tgt_col) ? cand_nb[CW-1:0] - tgt_col : tgt_col - cand_nb[CW-1:0];
        dr = (cand_nb[CW+RW-1:CW] >= tgt_row) ? cand_nb[CW+RW-1:CW] - tgt_row
                                              : tgt_row - cand_nb[CW+RW-1:CW];
        cand_score = SW'(dc) + SW'(dr);
`ifdef GHOST_FRIGHTENED_EN
        // Rotational rank from the LFSR start index: lowest legal rank wins.
        rank = cidx - rot_start;
        if (eval_mode == 2'b10) cand_score = SW'(rank);
`endif
        cand_better = cand_legal && (!best_vld || cand_score < best_score);

        // Final decision, valid in the cycle candidate 3 is scored.
        dec_dir = ghost_direction;
        dec_go  = 1'b0;
        if (rev_pend && rev_open) begin
            dec_dir = rev_dir;
            dec_go  = 1'b1;
        end else if (cand_better) begin
            dec_dir = cand_dir;
            dec_go  = 1'b1;
        end else if (best_vld) begin
            dec_dir = best_dir;
            dec_go  = 1'b1;
        end else if (rev_open) begin
            dec_dir = rev_dir;
            dec_go  = 1'b1;
        end

        off_sum = offset + OW'(SPEED);
        wrap    = (off_sum == OW'(TILE_SIZE));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            x               <= XW'(START_COL * TILE_SIZE);
            y               <= YW'(START_ROW * TILE_SIZE);
            tile_col        <= CW'(START_COL);
            tile_row        <= RW'(START_ROW);
            ghost_direction <= START_DIR;
            offset          <= '0;
            busy            <= 1'b0;
            moved           <= 1'b0;
            rev_pend        <= 1'b0;
            mode_q          <= mode;
            eval_mode       <= 2'b00;
            cidx            <= 2'd0;
            best_vld        <= 1'b0;
            best_score      <= '0;
            best_dir        <= 2'd0;
            mv_dir          <= START_DIR;
            mv_go           <= 1'b0;
`ifdef GHOST_FRIGHTENED_EN
            rot_start       <= 2'd0;
`endif
        end else begin
            moved  <= 1'b0;
            mode_q <= mode;
            case (state)
                IDLE: if (step) begin
                    busy <= 1'b1;
                    if (offset == '0) begin
                        state     <= EVAL;
                        cidx      <= 2'd0;
                        best_vld  <= 1'b0;
                        eval_mode <= mode;
`ifdef GHOST_FRIGHTENED_EN
                        rot_start <= lfsr[1:0];
`endif
                    end else begin
                        state  <= MOVE;
                        mv_dir <= ghost_direction;
                        mv_go  <= 1'b1;
                    end
                end
                EVAL: begin
                    if (cand_better) begin
                        best_vld   <= 1'b1;
                        best_score <= cand_score;
                        best_dir   <= cand_dir;
                    end
                    cidx <= cidx + 2'd1;
                    if (cidx == 2'd3) begin
                        state    <= MOVE;
                        mv_dir   <= dec_dir;
                        mv_go    <= dec_go;
                        rev_pend <= 1'b0;
                    end
                end
                MOVE: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    moved           <= 1'b1;
                    ghost_direction <= mv_dir;
                    if (mv_go) begin
                        offset <= wrap ? '0 : off_sum;
                        case (mv_dir)
                            `DIR_UP: begin
                                y <= y - YW'(SPEED);
                                if (wrap) tile_row <= tile_row - 1'b1;
                            end
                            `DIR_LEFT: begin
                                x <= x - XW'(SPEED);
                                if (wrap) tile_col <= tile_col - 1'b1;
                            end
                            `DIR_DOWN: begin
                                y <= y + YW'(SPEED);
                                if (wrap) tile_row <= tile_row + 1'b1;
                            end
                            default: begin
                                x <= x + XW'(SPEED);
                                if (wrap) tile_col <= tile_col + 1'b1;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
            // A mode change in the same cycle as a decision still arms the next reversal.
            if (mode != mode_q) rev_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ghost_nav.sv
// Bench for ghost_nav: directed scenarios plus randomized walks against a tile-level model.
module tb_ghost_nav;
    localparam int COLS = 32, ROWS = 16;
    localparam int UP = 0, LEFT = 1, DOWN = 2, RIGHT = 3;
    localparam int DC[4] = '{0, -1, 0, 1};
    localparam int DR[4] = '{-1, 0, 1, 0};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic step_a = 1'b0, step_b = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [4:0] target_col = '0;
    logic [3:0] target_row = '0;
    logic [ROWS*COLS-1:0] walls = '0;

    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic [1:0] dir_a, dir_b;
    logic [4:0] col_a, col_b;
    logic [3:0] row_a, row_b;
    logic busy_a, busy_b, moved_a, moved_b;

    int n_chk = 0, n_err = 0;
    int m_col, m_row, m_dir;
    bit m_rev;
    logic [15:0] tb_lfsr;

    ghost_nav #(.COLS(COLS), .ROWS(ROWS)) dut_a (
        .clk(clk), .reset(reset), .step(step_a), .mode(mode),
        .target_col(target_col), .target_row(target_row), .tilemap_walls(walls),
        .x(x_a), .y(y_a), .ghost_direction(dir_a), .tile_col(col_a), .tile_row(row_a),
        .busy(busy_a), .moved(moved_a));

    ghost_nav #(.SPEED(5), .COLS(COLS), .ROWS(ROWS)) dut_b (
        .clk(clk), .reset(reset), .step(step_b), .mode(mode),
        .target_col(target_col), .target_row(target_row), .tilemap_walls(walls),
        .x(x_b), .y(y_b), .ghost_direction(dir_b), .tile_col(col_b), .tile_row(row_b),
        .busy(busy_b), .moved(moved_b));

    always #5 clk = ~clk;

    // Reference sequence: x^16 + x^14 + x^13 + x^11, seeded with ACE1 at reset.
    always @(posedge clk) begin
        if (!reset) tb_lfsr <= 16'hACE1;
        else        tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_wall(input int c, input int r, input bit v);
        walls[r*COLS+c] = v;
    endtask

    task automatic base_walls();
        walls = '0;
        for (int c = 0; c < COLS; c++) begin
            set_wall(c, 7, 1'b1);
            set_wall(c, 9, 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; step_a = 1'b0; step_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns the negedge count at which moved was seen.
    task automatic step_go(input int which, output int lat, output int rot);
        rot = int'(tb_lfsr[1:0]);
        if (which == 0) step_a = 1'b1; else step_b = 1'b1;
        @(negedge clk);
        step_a = 1'b0; step_b = 1'b0;
        lat = 1;
        while (!(which == 0 ? moved_a : moved_b) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("moved_seen", int'(which == 0 ? moved_a : moved_b), 1);
    endtask

    function automatic bit open_t(input int c, input int r);
        if (c < 0 || c >= COLS || r < 0 || r >= ROWS) return 1'b0;
        return !walls[r*COLS+c];
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // One aligned decision and move of a TILE_SIZE-speed ghost.
    task automatic model_step(input int md, input int tc, input int tr, input int rot);
        int rv, nd, best, bd, tgc, tgr;
        bit go, fr;
        rv = (m_dir + 2) % 4;
        nd = m_dir;
        go = 1'b0;
        fr = 1'b0;
`ifdef GHOST_FRIGHTENED_EN
        fr = (md == 2);
`endif
        tgc = (md == 1) ? tc : 0;
        tgr = (md == 1) ? tr : 0;
        if (m_rev && open_t(m_col + DC[rv], m_row + DR[rv])) begin
            nd = rv; go = 1'b1;
        end else begin
            best = -1; bd = 1 << 30;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = fr ? (rot + k) % 4 : k;
                if (i != rv && open_t(m_col + DC[i], m_row + DR[i])) begin
                    if (fr) begin
                        if (best < 0) best = i;
                    end else if (absd(m_col + DC[i], tgc) + absd(m_row + DR[i], tgr) < bd) begin
                        bd = absd(m_col + DC[i], tgc) + absd(m_row + DR[i], tgr);
                        best = i;
                    end
                end
            end
            if (best >= 0) begin
                nd = best; go = 1'b1;
            end else if (open_t(m_col + DC[rv], m_row + DR[rv])) begin
                nd = rv; go = 1'b1;
            end
        end
        m_rev = 1'b0;
        m_dir = nd;
        if (go) begin
            m_col += DC[nd];
            m_row += DR[nd];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat, rot, exp_d, nm;
        base_walls();
        do_reset();

        chk("rst_x", x_a, 20);
        chk("rst_y", y_a, 160);
        chk("rst_dir", dir_a, RIGHT);
        chk("rst_col", col_a, 1);
        chk("rst_row", row_a, 8);
        chk("rst_busy", busy_a, 0);
        chk("rst_moved", moved_a, 0);

        // SPEED=5: only the aligned step evaluates.
        step_go(1, lat, rot);
        chk("b1_lat", lat, 6);
        chk("b1_x", x_b, 25);
        for (int s = 2; s <= 4; s++) begin
            step_go(1, lat, rot);
            chk("b_unaligned_lat", lat, 2);
            chk("b_x", x_b, 20 + 5 * s);
            chk("b_col", col_b, (s == 4) ? 2 : 1);
        end

        // Corridor step with extra steps during busy.
        @(negedge clk); step_a = 1'b1;
        @(negedge clk); step_a = 1'b0; chk("corr_busy_hi", busy_a, 1);
        @(negedge clk); step_a = 1'b1;
        @(negedge clk); step_a = 1'b1;
        @(negedge clk); step_a = 1'b0;
        @(negedge clk); chk("corr_moved_early", moved_a, 0);
        @(negedge clk);
        chk("corr_moved", moved_a, 1);
        chk("corr_x", x_a, 40);
        chk("corr_col", col_a, 2);
        chk("corr_busy_lo", busy_a, 0);
        @(negedge clk); chk("corr_moved_pulse", moved_a, 0);
        repeat (4) @(negedge clk);
        chk("corr_ignored_x", x_a, 40);

        step_go(0, lat, rot);
        chk("corr2_x", x_a, 60);

        // Dead end at (3,8).
        set_wall(4, 8, 1'b1);
        step_go(0, lat, rot);
        chk("dead_dir", dir_a, LEFT);
        chk("dead_x", x_a, 40);

        // Junction at (2,8) facing left: up and left tie at distance 9.
        set_wall(2, 7, 1'b0);
        step_go(0, lat, rot);
        chk("tie_dir", dir_a, UP);
        chk("tie_y", y_a, 140);
        chk("tie_row", row_a, 7);

        // At (2,7) facing up with only left open.
        set_wall(2, 6, 1'b1);
        set_wall(1, 7, 1'b0);
        step_go(0, lat, rot);
        chk("left_dir", dir_a, LEFT);
        chk("left_x", x_a, 20);

        // Reset during EVAL leaves no partial update.
        @(negedge clk); step_a = 1'b1;
        @(negedge clk); step_a = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_y", y_a, 160);
        chk("abort_dir", dir_a, RIGHT);
        chk("abort_moved", moved_a, 0);
        chk("abort_busy", busy_a, 0);

        // Mode change forces a reversal even though the chase target lies ahead.
        base_walls();
        mode = 2'b01; target_col = 5'd31; target_row = 4'd8;
        step_go(0, lat, rot);
        chk("modrev_dir", dir_a, LEFT);
        chk("modrev_x", x_a, 0);
        step_go(0, lat, rot);
        chk("corner_rev_dir", dir_a, RIGHT);
        step_go(0, lat, rot);
        chk("revclr_x", x_a, 40);

        // Mode 10: LFSR-ordered choice when built in, scatter otherwise.
        mode = 2'b00;
        do_reset();
        base_walls();
        set_wall(0, 8, 1'b1);
        set_wall(1, 7, 1'b0);
        set_wall(1, 9, 1'b0);
        mode = 2'b10;
        step_go(0, lat, rot);
`ifdef GHOST_FRIGHTENED_EN
        exp_d = -1;
        for (int k = 0; k < 4; k++)
            if (exp_d < 0 && ((rot + k) % 4) != LEFT) exp_d = (rot + k) % 4;
`else
        exp_d = UP;
`endif
        chk("fright_dir", dir_a, exp_d);

        // Boxed in: moved pulses, nothing moves.
        mode = 2'b00;
        do_reset();
        base_walls();
        set_wall(0, 8, 1'b1);
        set_wall(2, 8, 1'b1);
        step_go(0, lat, rot);
        chk("stall_x", x_a, 20);
        chk("stall_dir", dir_a, RIGHT);

        // Randomized walks against the model.
        mode = 2'b00;
        do_reset();
        m_col = 1; m_row = 8; m_dir = RIGHT; m_rev = 1'b0;
        for (int s = 0; s < 60; s++) begin
            if (s % 15 == 0)
                for (int i = 0; i < COLS * ROWS; i++) walls[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                nm = $urandom_range(0, 3);
                if (nm != int'(mode)) m_rev = 1'b1;
                mode = 2'(nm);
            end
            target_col = 5'($urandom_range(0, COLS - 1));
            target_row = 4'($urandom_range(0, ROWS - 1));
            step_go(0, lat, rot);
            model_step(int'(mode), int'(target_col), int'(target_row), rot);
            chk("rnd_dir", dir_a, m_dir);
            chk("rnd_col", col_a, m_col);
            chk("rnd_row", row_a, m_row);
            chk("rnd_x", x_a, m_col * 20);
            chk("rnd_y", y_a, m_row * 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
